vram_arbiter: RTL and testbench

- Shares the single-port VRAM between three requesters: the video fetch unit, the host register interface and the blitter.
- Fixed priority: video > host > blitter. The blitter receives every slot nobody else claims, announced one cycle ahead on `blit_cycle_o`.
- Sits between `blitter`, the video generator, the host bus decoder and the VRAM macro, and owns all VRAM port signals.

---
 rtl/vram_arbiter_pkg.sv | 12 +
 rtl/vram_arbiter.sv | 155 +++++++++++++++
 tb/tb_vram_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the VRAM arbiter: slot owner encodings.
package vram_arbiter_pkg;

  // Owner of a VRAM slot; also used to tag in-flight read returns.
  typedef enum logic [1:0] {
    SLOT_NONE = 2'd0,
    SLOT_VID  = 2'd1,
    SLOT_HOST = 2'd2,
    SLOT_BLIT = 2'd3
  } slot_e;

endpackage

// File: rtl/vram_arbiter.sv
// Fixed-priority VRAM slot arbiter: video > host > blitter.
// The blitter inherits every unclaimed slot and is told one cycle ahead.
module vram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              video_ena_i,
  input  logic              vid_req_i,
  input  logic [ADDR_W-1:0] vid_addr_i,
  output logic              vid_valid_o,
  output logic [DATA_W-1:0] vid_data_o,
  input  logic              host_req_i,
  input  logic              host_wr_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_data_i,
  output logic              host_busy_o,
  output logic              host_ack_o,
  output logic [DATA_W-1:0] host_data_o,
  output logic              blit_cycle_o,
  input  logic              blit_sel_i,
  input  logic              blit_wr_i,
  input  logic [ADDR_W-1:0] blit_addr_i,
  input  logic [DATA_W-1:0] blit_data_i,
  output logic [DATA_W-1:0] blit_data_o,
  output logic              vram_sel_o,
  output logic              vram_wr_o,
  output logic [ADDR_W-1:0] vram_addr_o,
  output logic [DATA_W-1:0] vram_data_o,
  input  logic [DATA_W-1:0] vram_data_i
);
  import vram_arbiter_pkg::*;

  slot_e             slot_q, slot_d;
  slot_e             rd_owner_q, rd_owner_d;
  logic              host_pend_q, host_pend_d;
  logic              host_busy_q, host_busy_d;
  logic              host_ack_q, host_ack_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic [ADDR_W-1:0] vid_addr_q, vid_addr_d;
  logic              host_wr_q, host_wr_d;
  logic [ADDR_W-1:0] host_addr_q, host_addr_d;
  logic [DATA_W-1:0] host_wdata_q, host_wdata_d;
  logic              vid_claim;
  logic              host_accept;

  // Next-slot decision, host capture and read-return bookkeeping.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the block infers a latch.
    slot_d       = SLOT_BLIT;
    vid_addr_d   = vid_addr_q;
    host_pend_d  = host_pend_q;
    host_busy_d  = host_busy_q;
    host_wr_d    = host_wr_q;
    host_addr_d  = host_addr_q;
    host_wdata_d = host_wdata_q;
    vid_claim    = vid_req_i & video_ena_i;
    host_accept  = host_req_i & ~host_busy_q;

    if (vid_claim) begin
      slot_d     = SLOT_VID;
      vid_addr_d = vid_addr_i;
    end else if (host_pend_q) begin
      slot_d      = SLOT_HOST;
      host_pend_d = 1'b0;
    end

    // Busy covers pending, so an accept never collides with a HOST grant or an ack.
    if (host_accept) begin
      host_pend_d  = 1'b1;
      host_busy_d  = 1'b1;
      host_wr_d    = host_wr_i;
      host_addr_d  = host_addr_i;
      host_wdata_d = host_data_i;
    end
    if (host_ack_q) begin
      host_busy_d = 1'b0;
    end

    host_ack_d   = (slot_q == SLOT_HOST);
    rd_owner_d   = (vram_sel_o && !vram_wr_o) ? slot_q : SLOT_NONE;
    host_rdata_d = (rd_owner_q == SLOT_HOST) ? vram_data_i : host_rdata_q;
  end

  // VRAM port follows the owner of the current slot.
  always_comb begin
    vram_sel_o  = 1'b0;
    vram_wr_o   = 1'b0;
    vram_addr_o = '0;
    vram_data_o = '0;
    unique case (slot_q)
      SLOT_NONE: ;
      SLOT_VID: begin
        vram_sel_o  = 1'b1;
        vram_addr_o = vid_addr_q;
      end
      SLOT_HOST: begin
        vram_sel_o  = 1'b1;
        vram_wr_o   = host_wr_q;
        vram_addr_o = host_addr_q;
        vram_data_o = host_wdata_q;
      end
      SLOT_BLIT: begin
        if (blit_sel_i) begin
          vram_sel_o  = 1'b1;
          vram_wr_o   = blit_wr_i;
          vram_addr_o = blit_addr_i;
          vram_data_o = blit_data_i;
        end
      end
    endcase
  end

  // The announcement is the decision that loads slot_q at the coming edge.
  assign blit_cycle_o = ~reset_i & (slot_d == SLOT_BLIT);

  // Read data is steered to whoever issued the read one cycle earlier.
  assign vid_valid_o = (rd_owner_q == SLOT_VID);
  assign vid_data_o  = vid_valid_o ? vram_data_i : '0;
  assign blit_data_o = (rd_owner_q == SLOT_BLIT) ? vram_data_i : '0;
  assign host_data_o = (rd_owner_q == SLOT_HOST) ? vram_data_i : host_rdata_q;
  assign host_ack_o  = host_ack_q;
  assign host_busy_o = host_busy_q;

  // Control state; reset drops any pending host access and in-flight return.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (reset_i) begin
      slot_q       <= SLOT_NONE;
      rd_owner_q   <= SLOT_NONE;
      host_pend_q  <= 1'b0;
      host_busy_q  <= 1'b0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      slot_q       <= slot_d;
      rd_owner_q   <= rd_owner_d;
      host_pend_q  <= host_pend_d;
      host_busy_q  <= host_busy_d;
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  // Address/data hold registers; only observed while their owner holds the slot.
  always_ff @(posedge clk) begin
    // NOTE: datapath holds are left unreset; the slot gating keeps their contents invisible.
    vid_addr_q   <= vid_addr_d;
    host_wr_q    <= host_wr_d;
    host_addr_q  <= host_addr_d;
    host_wdata_q <= host_wdata_d;
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: VRAM macro model, cycle-level behavioural model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_vram_arbiter;

  localparam int M_NONE = 0;
  localparam int M_VID  = 1;
  localparam int M_HOST = 2;
  localparam int M_BLIT = 3;

  logic        clk;
  logic        reset_i;
  logic        video_ena_i, vid_req_i;
  logic [15:0] vid_addr_i;
  logic        vid_valid_o;
  logic [15:0] vid_data_o;
  logic        host_req_i, host_wr_i;
  logic [15:0] host_addr_i, host_data_i;
  logic        host_busy_o, host_ack_o;
  logic [15:0] host_data_o;
  logic        blit_cycle_o;
  logic        blit_sel_i, blit_wr_i;
  logic [15:0] blit_addr_i, blit_data_i, blit_data_o;
  logic        vram_sel_o, vram_wr_o;
  logic [15:0] vram_addr_o, vram_data_o, vram_data_i;

  int n_vec = 0;
  int n_err = 0;
  bit run_cmp = 0;

  vram_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .reset_i(reset_i),
    .video_ena_i(video_ena_i), .vid_req_i(vid_req_i), .vid_addr_i(vid_addr_i),
    .vid_valid_o(vid_valid_o), .vid_data_o(vid_data_o),
    .host_req_i(host_req_i), .host_wr_i(host_wr_i), .host_addr_i(host_addr_i),
    .host_data_i(host_data_i), .host_busy_o(host_busy_o), .host_ack_o(host_ack_o),
    .host_data_o(host_data_o), .blit_cycle_o(blit_cycle_o),
    .blit_sel_i(blit_sel_i), .blit_wr_i(blit_wr_i), .blit_addr_i(blit_addr_i),
    .blit_data_i(blit_data_i), .blit_data_o(blit_data_o),
    .vram_sel_o(vram_sel_o), .vram_wr_o(vram_wr_o), .vram_addr_o(vram_addr_o),
    .vram_data_o(vram_data_o), .vram_data_i(vram_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM macro: synchronous single port, read data one cycle after select.
  logic [15:0] mem [0:65535];
  logic [15:0] vram_rd;
  assign vram_data_i = vram_rd;
  initial begin
    vram_rd = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
    mem[16'h1234] = 16'hBEEF;
  end
  always @(posedge clk) begin
    if (vram_sel_o) begin
      if (vram_wr_o) mem[vram_addr_o] <= vram_data_o;
      else           vram_rd <= mem[vram_addr_o];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state describing the current cycle.
  int          m_owner = M_NONE;
  logic [15:0] m_vaddr = '0;
  bit          m_hvalid = 0;
  logic        m_h_wr = 0;
  logic [15:0] m_h_addr = '0, m_h_data = '0;
  logic        m_iss_wr = 0;
  logic [15:0] m_iss_addr = '0, m_iss_data = '0;
  bit          m_busy = 0, m_ack = 0;
  int          m_ret_who = M_NONE;
  logic [15:0] m_ret_data = '0, m_hold = '0;

  logic        e_sel, e_wr, e_blit;
  logic [15:0] e_addr, e_wdata;
  int          n_owner, n_ret_who;
  logic [15:0] n_ret_data;
  bit          n_busy, n_ack;

  // Every cycle: derive expected outputs from the model, compare, then advance it.
  always @(negedge clk) begin
    if (run_cmp) begin
      e_sel = 0; e_wr = 0; e_addr = '0; e_wdata = '0;
      case (m_owner)
        M_VID:  begin e_sel = 1; e_addr = m_vaddr; end
        M_HOST: begin e_sel = 1; e_wr = m_iss_wr; e_addr = m_iss_addr; e_wdata = m_iss_data; end
        M_BLIT: if (blit_sel_i) begin
          e_sel = 1; e_wr = blit_wr_i; e_addr = blit_addr_i; e_wdata = blit_data_i;
        end
        default: ;
      endcase
      e_blit = !reset_i && !(vid_req_i && video_ena_i) && !m_hvalid;

      check("vram_sel", vram_sel_o, e_sel);
      check("vram_wr", vram_wr_o, e_wr);
      if (e_sel) begin
        check("vram_addr", vram_addr_o, e_addr);
        if (e_wr) check("vram_data", vram_data_o, e_wdata);
      end
      check("blit_cycle", blit_cycle_o, e_blit);
      check("vid_valid", vid_valid_o, m_ret_who == M_VID);
      check("vid_data", vid_data_o, (m_ret_who == M_VID) ? m_ret_data : 16'h0);
      check("blit_data", blit_data_o, (m_ret_who == M_BLIT) ? m_ret_data : 16'h0);
      check("host_ack", host_ack_o, m_ack);
      check("host_data", host_data_o, (m_ret_who == M_HOST) ? m_ret_data : m_hold);
      check("host_busy", host_busy_o, m_busy);

      if (reset_i) begin
        m_owner = M_NONE; m_ret_who = M_NONE; m_ack = 0; m_busy = 0;
        m_hvalid = 0; m_hold = '0;
      end else begin
        if (m_ret_who == M_HOST) m_hold = m_ret_data;
        n_ret_who  = (e_sel && !e_wr) ? m_owner : M_NONE;
        n_ret_data = mem[e_addr];
        n_ack      = (m_owner == M_HOST);
        n_busy     = m_ack ? 0 : m_busy;
        if (vid_req_i && video_ena_i) begin
          n_owner = M_VID; m_vaddr = vid_addr_i;
        end else if (m_hvalid) begin
          n_owner = M_HOST; m_hvalid = 0;
          m_iss_wr = m_h_wr; m_iss_addr = m_h_addr; m_iss_data = m_h_data;
        end else begin
          n_owner = M_BLIT;
        end
        if (host_req_i && !m_busy) begin
          n_busy = 1; m_hvalid = 1;
          m_h_wr = host_wr_i; m_h_addr = host_addr_i; m_h_data = host_data_i;
        end
        m_owner = n_owner; m_ret_who = n_ret_who; m_ret_data = n_ret_data;
        m_ack = n_ack; m_busy = n_busy;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg;
    @(negedge clk);
  endtask

  int acks;

  initial begin
    reset_i = 1; video_ena_i = 1; vid_req_i = 0; vid_addr_i = '0;
    host_req_i = 0; host_wr_i = 0; host_addr_i = '0; host_data_i = '0;
    blit_sel_i = 0; blit_wr_i = 0; blit_addr_i = '0; blit_data_i = '0;

    // Reset held three cycles.
    tick; run_cmp = 1;
    tick; at_neg;
    check("rst_vram_sel", vram_sel_o, 0);
    check("rst_blit_cycle", blit_cycle_o, 0);
    check("rst_busy", host_busy_o, 0);
    check("rst_vid_valid", vid_valid_o, 0);
    tick; reset_i = 0; at_neg;
    check("rel_blit_cycle", blit_cycle_o, 1);
    check("rel_vram_sel", vram_sel_o, 0);
    tick; at_neg;
    check("rel_idle_sel", vram_sel_o, 0);

    // Host read of 0x1234, no video.
    tick; host_req_i = 1; host_wr_i = 0; host_addr_i = 16'h1234; at_neg;
    check("hr_busy_c0", host_busy_o, 0);
    tick; host_req_i = 0; at_neg;
    check("hr_busy_c1", host_busy_o, 1);
    check("hr_blit_c1", blit_cycle_o, 0);
    tick; at_neg;
    check("hr_sel_c2", vram_sel_o, 1);
    check("hr_addr_c2", vram_addr_o, 16'h1234);
    tick; at_neg;
    check("hr_ack_c3", host_ack_o, 1);
    check("hr_data_c3", host_data_o, 16'hBEEF);
    check("hr_busy_c3", host_busy_o, 1);
    tick; at_neg;
    check("hr_busy_c4", host_busy_o, 0);
    check("hr_hold_c4", host_data_o, 16'hBEEF);

    // Video request arrives as the host becomes pending.
    tick; host_req_i = 1; host_addr_i = 16'h0100; at_neg;
    tick; host_req_i = 0; vid_req_i = 1; vid_addr_i = 16'h0040; at_neg;
    tick; vid_req_i = 0; at_neg;
    check("vh_addr_vid", vram_addr_o, 16'h0040);
    tick; at_neg;
    check("vh_addr_host", vram_addr_o, 16'h0100);
    check("vh_vid_valid", vid_valid_o, 1);
    check("vh_vid_data", vid_data_o, 16'h5A1A);
    check("vh_ack_early", host_ack_o, 0);
    tick; at_neg;
    check("vh_ack", host_ack_o, 1);
    check("vh_host_data", host_data_o, 16'h5B5A);
    tick; at_neg;

    // Five video requests starve a writing blitter.
    for (int i = 0; i < 5; i++) begin
      tick;
      vid_req_i = 1; vid_addr_i = 16'h0010 + 16'(i);
      blit_sel_i = 1; blit_wr_i = 1; blit_addr_i = 16'h3000; blit_data_i = 16'hDEAD;
      at_neg;
      check("vb_blit_cycle", blit_cycle_o, 0);
      if (i > 0) begin
        check("vb_no_write", vram_wr_o, 0);
        check("vb_vid_addr", vram_addr_o, 16'h0010 + 16'(i - 1));
      end
    end
    tick; vid_req_i = 0; at_neg;
    check("vb_resume", blit_cycle_o, 1);
    check("vb_last_vid", vram_addr_o, 16'h0014);
    check("vb_no_write5", vram_wr_o, 0);
    tick; at_neg;
    check("vb_blit_wr", vram_wr_o, 1);
    check("vb_blit_addr", vram_addr_o, 16'h3000);
    tick; blit_wr_i = 0; at_neg;
    check("vb_blit_rd", vram_sel_o, 1);
    tick; blit_sel_i = 0; at_neg;
    check("vb_blit_data", blit_data_o, 16'hDEAD);

    // Host strobes while busy are dropped.
    acks = 0;
    tick; host_req_i = 1; host_wr_i = 1; host_addr_i = 16'h0200; host_data_i = 16'h1111; at_neg;
    for (int c = 1; c < 9; c++) begin
      tick;
      host_req_i  = (c < 4);
      host_addr_i = 16'h2222; host_data_i = 16'h2222;
      at_neg;
      if (host_ack_o) acks++;
      check("bz_no_2222", vram_sel_o && vram_addr_o == 16'h2222, 0);
      if (c == 2) begin
        check("bz_addr", vram_addr_o, 16'h0200);
        check("bz_wr", vram_wr_o, 1);
      end
    end
    check("bz_ack_count", acks, 1);
    host_wr_i = 0;

    // Video disabled: requests ignored.
    for (int i = 0; i < 4; i++) begin
      tick; video_ena_i = 0; vid_req_i = 1; vid_addr_i = 16'h0777; at_neg;
      check("ve_blit_cycle", blit_cycle_o, 1);
      check("ve_vid_valid", vid_valid_o, 0);
    end
    tick; vid_req_i = 0; video_ena_i = 1; at_neg;
    check("ve_vid_valid_end", vid_valid_o, 0);

    // Reset during a pending host read drops it.
    tick; host_req_i = 1; host_addr_i = 16'h1234; at_neg;
    tick; host_req_i = 0; reset_i = 1; at_neg;
    check("mr_busy_in_reset", host_busy_o, 1);
    tick; reset_i = 0; at_neg;
    check("mr_busy", host_busy_o, 0);
    check("mr_sel", vram_sel_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick; at_neg;
      check("mr_no_ack", host_ack_o, 0);
    end

    tick; at_neg;
    tick; at_neg;
    run_cmp = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
